key_schedule_unit: RTL
======================

Name: key_schedule_unit

Overview:
Iterative AES-128 key expansion engine upstream of the buffered round and inverse round stages. It accepts a 128-bit cipher key, generates all NUM_ROUNDS+1 round keys at one per clock, and holds them in an internal register file. Round stages read keys through an indexed, registered read port. Forward rounds read index r; inverse rounds read index NUM_ROUNDS-r.

Parameters:
NUM_ROUNDS, `NUM_ROUNDS (10), number of AES rounds; the register file holds NUM_ROUNDS+1 keys.
IDX_W, 4, width of the round-key index; must satisfy 2**IDX_W > NUM_ROUNDS.

Ports:
clock  input  1  single system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request to load keyIn and begin expansion.
keyIn  input  128 (roundKey_t)  cipher key; sampled only on an accepted start.
busy  output  1  expansion in progress.
keysValid  output  1  all round keys are present and stable.
rdIndex  input  IDX_W  round-key index to read.
rdKey  output  128 (roundKey_t)  registered read data.

Behaviour:
- Reset, asynchronous: FSM goes to IDLE; busy=0, keysValid=0, rdKey=0; all register-file slots and the round counter are cleared to 0.
- FSM states are IDLE, EXPAND and READY.
- IDLE:
  - start=1 at an edge writes keyIn to slot 0, sets counter=1 and moves to EXPAND.
  - busy goes high from that edge.
- EXPAND:
  - Each edge writes slot[counter] = step(slot[counter-1], Rcon[counter]), then increments the counter.
  - step() is the standard FIPS-197 expansion: w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - The edge that writes slot NUM_ROUNDS moves to READY, sets keysValid=1 and clears busy.
  - Latency: keysValid rises on the NUM_ROUNDS-th edge after the edge that accepted start (10 cycles by default).
- start while in EXPAND is ignored. keyIn is not re-sampled and the expansion continues undisturbed.
- start while in READY restarts expansion:
  - The same edge writes keyIn to slot 0, clears keysValid, sets busy and moves to EXPAND.
  - Slots 1..NUM_ROUNDS keep their stale values until overwritten.
- Read port:
  - rdKey <= slot[rdIndex] on every edge, in any state (1-cycle latency).
  - rdIndex > NUM_ROUNDS returns 0.
  - Reads are not gated by keysValid. Consumers must qualify reads with keysValid.
- Read and write to the same slot in one cycle returns the old (pre-write) value.
- Reset asserted mid-expansion aborts immediately. All keys are lost and a fresh start is required.
- busy and keysValid are never both 1.

Decomposition:
- The shared AES definitions package holds:
  - roundKey_t / word typedefs
  - NUM_ROUNDS macro
  - the Rcon table, indexed 1..10: 01,02,04,08,10,20,40,80,1B,36
  - the S-box SubWord function, shared with the round stages
  - the FSM state enum
- Sub-module key_expand_step is purely combinational: previous key plus Rcon byte in, next round key out. It is reusable by a future fully pipelined key path.

Test Plan:
1. Reset for 2 cycles, then idle: busy=0, keysValid=0, and rdKey=0 for every rdIndex.
2. Start with keyIn=000102030405060708090A0B0C0D0E0F:
   - keysValid rises exactly 10 edges after the start edge.
   - rdIndex=0 returns 000102030405060708090A0B0C0D0E0F.
   - rdIndex=1 returns D6AA74FDD2AF72FADAA678F1D6AB76FE.
   - rdIndex=10 returns 13111D7FE3944A17F307A78B4D2B30C5.
3. Start with keyIn=2B7E151628AED2A6ABF7158809CF4F3C:
   - rdIndex=1 returns A0FAFE1788542CB123A339392A6C7605.
   - rdIndex=10 returns D014F9A8C9EE2589E13F0CC8B6630CA6.
   - rdIndex=11 and rdIndex=15 return 0.
4. Start key A, then at the 4th edge of EXPAND pulse start with key B. Required: the pulse is ignored, keysValid timing is unchanged, and the slot-10 key equals key A's expansion.
5. In READY, start with key B:
   - keysValid falls on the next edge.
   - keysValid re-rises 10 edges later.
   - rdIndex=10 then returns key B's expansion.
6. Assert reset asynchronously between edges during EXPAND. busy, keysValid and rdKey must go to 0 without waiting for a clock edge, and a subsequent start expands correctly.

Source files
------------

// File: rtl/key_schedule_unit_pkg.sv
// Shared AES-128 definitions: key/word types, round count, Rcon table,
// S-box based SubWord and the key-schedule FSM state encoding.
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif

package key_schedule_unit_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] roundKey_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } ks_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constant for round 1..10; other indices yield 0.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/key_schedule_unit_key_expand_step.sv
// One AES-128 key-expansion step: previous round key plus Rcon byte in,
// next round key out. Purely combinational.
module key_expand_step
  import key_schedule_unit_pkg::*;
(
  input  roundKey_t  prev_key_i,
  input  logic [7:0] rcon_i,
  output roundKey_t  next_key_o
);

  word_t w0, w1, w2, w3;
  word_t n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev_key_i;

  // RotWord is a one-byte left rotation of the last word.
  assign n0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon_i, 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_unit.sv
// Iterative AES-128 key schedule: expands one round key per clock into a
// register file and serves them through a registered indexed read port.
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif

module key_schedule_unit
  import key_schedule_unit_pkg::*;
#(
  parameter int NUM_ROUNDS = `NUM_ROUNDS,
  parameter int IDX_W      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  roundKey_t        keyIn,
  output logic             busy,
  output logic             keysValid,
  input  logic [IDX_W-1:0] rdIndex,
  output roundKey_t        rdKey
);

  ks_state_e        state_q;
  logic [IDX_W-1:0] count_q;
  logic             busy_q;
  logic             valid_q;
  roundKey_t        rd_key_q;
  roundKey_t        slot_q [NUM_ROUNDS+1];

  roundKey_t prev_key_d;
  roundKey_t next_key_d;
  roundKey_t rd_key_d;

  always_comb begin
    prev_key_d = '0;
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      if (count_q == IDX_W'(i + 1)) prev_key_d = slot_q[i];
    end
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    rd_key_d = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (rdIndex == IDX_W'(i)) rd_key_d = slot_q[i];
    end
  end

  key_expand_step u_step (
    .prev_key_i (prev_key_d),
    .rcon_i     (rcon(4'(count_q))),
    .next_key_o (next_key_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      rd_key_q <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) slot_q[i] <= '0;
    end else begin
      rd_key_q <= rd_key_d;
      case (state_q)
        ST_IDLE, ST_READY: begin
          if (start) begin
            slot_q[0] <= keyIn;
            count_q   <= IDX_W'(1);
            busy_q    <= 1'b1;
            valid_q   <= 1'b0;
            state_q   <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          for (int i = 1; i <= NUM_ROUNDS; i++) begin
            if (count_q == IDX_W'(i)) slot_q[i] <= next_key_d;
          end
          count_q <= count_q + IDX_W'(1);
          if (count_q == IDX_W'(NUM_ROUNDS)) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ST_READY;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign keysValid = valid_q;
  assign rdKey     = rd_key_q;

endmodule
